// File: rtl/aes_sink_pkg.sv
// Shared types for the AES ciphertext sink: FSM states and the ciphertext beat type.
package aes_sink_pkg;

    typedef enum logic {SNK_RUN, SNK_LOCKED} snk_state_e;

    localparam int CT_W = 128;

    typedef logic [CT_W-1:0] ct_t;

endpackage

// File: rtl/aes_ct_fifo.sv
// FWFT FIFO: head visible on rdata the cycle after the push edge, zero when empty.
// Caller must not push when full without a same-cycle pop; flush empties it on the next edge.
module aes_ct_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/aes_ct_sink.sv
// AES ciphertext sink: buffers beats into an FWFT FIFO toward ready/valid; flags/outputs update one edge later.
// Backpressure: beats arriving while full are dropped and counted; override alarms lock and flush the path.
module aes_ct_sink
    import aes_sink_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ALARM_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  ct_t                      ct_i,
    input  logic                     valid_i,
    input  logic                     override_i,
    output ct_t                      ct_o,
    output logic                     ct_valid_o,
    input  logic                     ct_ready_i,
    input  logic                     clear_i,
    output logic                     alarm_o,
    output logic                     locked_o,
    output logic [CNT_W-1:0]         alarm_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    snk_state_e       state;
    snk_state_e       state_nxt;
    logic             run;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic             flush;
    logic             alarm;
    logic [CNT_W-1:0] alarm_cnt;
    logic [CNT_W-1:0] alarm_inc;
    logic [CNT_W-1:0] drop_cnt;

    assign alarm_inc = (alarm_cnt == CNT_MAX) ? alarm_cnt : alarm_cnt + CNT_ONE;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= SNK_RUN;
        else       state <= state_nxt;
    end

    // Override outranks clear so a clear cannot mask a concurrent alarm.
    always_comb begin
        state_nxt = state;
        case (state)
            SNK_RUN:    if (override_i && alarm_inc == THRESH) state_nxt = SNK_LOCKED;
            SNK_LOCKED: if (clear_i && !override_i)            state_nxt = SNK_RUN;
            default:    state_nxt = SNK_RUN;
        endcase
    end

    always_comb begin
        run        = (state == SNK_RUN);
        locked_o   = (state == SNK_LOCKED);
        ct_valid_o = !empty && run;
    end

    assign pop   = ct_valid_o && ct_ready_i;
    assign push  = valid_i && !override_i && run && (!full || pop);
    assign drop  = valid_i && !override_i && run && full && !pop;
    assign flush = (state_nxt != state);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (override_i) begin
                alarm     <= 1'b1;
                alarm_cnt <= alarm_inc;
            end else if (clear_i) begin
                alarm     <= 1'b0;
                alarm_cnt <= '0;
            end
            if (drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    assign alarm_o     = alarm;
    assign alarm_cnt_o = alarm_cnt;
    assign drop_cnt_o  = drop_cnt;

    aes_ct_fifo #(
        .DEPTH (DEPTH),
        .W     (CT_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (ct_i),
        .pop   (pop),
        .flush (flush),
        .rdata (ct_o),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

endmodule
